// File: rtl/ins_fetch_pkg.sv
// Shared definitions for the instruction fetch stage: PC update modes, FSM states, default NOP word.
package ins_fetch_pkg;

    localparam logic [1:0] PC_CTRL_INC  = 2'b00;
    localparam logic [1:0] PC_CTRL_JMP  = 2'b01;
    localparam logic [1:0] PC_CTRL_REL  = 2'b10;
    localparam logic [1:0] PC_CTRL_HOLD = 2'b11;

    localparam logic [15:0] NOP_WORD_DEFAULT = 16'h0000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/ins_fetch_if.sv
// Instruction-memory read port: request/acknowledge handshake between fetch stage and memory.
interface ins_fetch_if #(
    parameter int unsigned DWIDTH = 16,
    parameter int unsigned AWIDTH = 8
);
    logic [AWIDTH-1:0] mem_addr;
    logic              mem_rd;
    logic [DWIDTH-1:0] mem_rdata;
    logic              mem_ack;

    modport master (
        output mem_addr,
        output mem_rd,
        input  mem_rdata,
        input  mem_ack
    );

    modport slave (
        input  mem_addr,
        input  mem_rd,
        output mem_rdata,
        output mem_ack
    );
endinterface

// File: rtl/ins_fetch_pc_reg.sv
// Program counter register with increment / absolute jump / relative branch / hold update.
module pc_reg
    import ins_fetch_pkg::*;
#(
    parameter int unsigned AWIDTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en_pc_pulse_i,
    input  logic [1:0]        pc_ctrl_i,
    input  logic [7:0]        offset_addr_i,
    output logic [AWIDTH-1:0] pc_o
);

    logic [AWIDTH-1:0] pc_q;
    logic [AWIDTH-1:0] pc_d;
    logic [AWIDTH-1:0] off_zext;
    logic [AWIDTH-1:0] off_sext;

    assign off_zext = AWIDTH'(offset_addr_i);
    assign off_sext = AWIDTH'($signed(offset_addr_i));

    // All updates wrap modulo 2^AWIDTH through natural truncation of the sum.
    always_comb begin
        pc_d = pc_q;
        if (en_pc_pulse_i) begin
            case (pc_ctrl_i)
                PC_CTRL_INC: pc_d = pc_q + AWIDTH'(1);
                PC_CTRL_JMP: pc_d = off_zext;
                PC_CTRL_REL: pc_d = pc_q + off_sext;
                default:     pc_d = pc_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q <= '0;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/ins_fetch.sv
// Instruction fetch stage: owns the PC and performs req/ack reads of instruction memory.
// Optional macro IF_TIMEOUT_EN aborts a stalled read after TIMEOUT cycles and returns NOP_WORD.
module ins_fetch
    import ins_fetch_pkg::*;
#(
    parameter int unsigned       DWIDTH   = 16,
    parameter int unsigned       AWIDTH   = 8,
    parameter int unsigned       TIMEOUT  = 15,
    parameter logic [DWIDTH-1:0] NOP_WORD = DWIDTH'(NOP_WORD_DEFAULT)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en_ram_in,
    input  logic              en_pc_pulse,
    input  logic [1:0]        pc_ctrl,
    input  logic [7:0]        offset_addr,
    ins_fetch_if.master       mem,
    output logic [DWIDTH-1:0] ins,
    output logic              en_ram_out,
    output logic [AWIDTH-1:0] pc,
    output logic              busy,
    output logic              fetch_err
);

    if (AWIDTH < 8 || TIMEOUT < 1 || $bits(NOP_WORD) != DWIDTH) begin : g_bad_cfg
        $error("ins_fetch: AWIDTH must be >= 8 and TIMEOUT >= 1");
    end

    fetch_state_e      state_q, state_d;
    logic [AWIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [DWIDTH-1:0] ins_q, ins_d;
    logic              err_q, err_d;

`ifdef IF_TIMEOUT_EN
    localparam int unsigned CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] tmo_q, tmo_d;
`endif

    pc_reg #(
        .AWIDTH(AWIDTH)
    ) u_pc_reg (
        .clk          (clk),
        .rst          (rst),
        .en_pc_pulse_i(en_pc_pulse),
        .pc_ctrl_i    (pc_ctrl),
        .offset_addr_i(offset_addr),
        .pc_o         (pc)
    );

    // mem_addr samples the pre-update pc, so a same-cycle PC pulse does not leak into the fetch.
    always_comb begin
        state_d    = state_q;
        mem_addr_d = mem_addr_q;
        ins_d      = ins_q;
        err_d      = err_q;
`ifdef IF_TIMEOUT_EN
        tmo_d      = '0;
`endif
        if (en_ram_in && state_q != ST_IDLE) begin
            err_d = 1'b1;
        end
        case (state_q)
            ST_IDLE: begin
                if (en_ram_in) begin
                    mem_addr_d = pc;
                    state_d    = ST_REQ;
                end
            end
            ST_REQ: begin
                if (mem.mem_ack) begin
                    ins_d   = mem.mem_rdata;
                    state_d = ST_RESP;
                end
`ifdef IF_TIMEOUT_EN
                else if (tmo_q == CW'(TIMEOUT - 1)) begin
                    ins_d   = NOP_WORD;
                    err_d   = 1'b1;
                    state_d = ST_RESP;
                end else begin
                    tmo_d = tmo_q + CW'(1);
                end
`endif
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            mem_addr_q <= '0;
            ins_q      <= '0;
            err_q      <= 1'b0;
`ifdef IF_TIMEOUT_EN
            tmo_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            mem_addr_q <= mem_addr_d;
            ins_q      <= ins_d;
            err_q      <= err_d;
`ifdef IF_TIMEOUT_EN
            tmo_q      <= tmo_d;
`endif
        end
    end

    assign mem.mem_addr = mem_addr_q;
    assign mem.mem_rd   = (state_q == ST_REQ);
    assign ins          = ins_q;
    assign en_ram_out   = (state_q == ST_RESP);
    assign busy         = (state_q != ST_IDLE);
    assign fetch_err    = err_q;

endmodule

// File: tb/tb_ins_fetch.sv
// Scoreboard bench for ins_fetch: transaction-level model queues expectations, a negedge monitor checks them.
module tb_ins_fetch;
    import ins_fetch_pkg::*;

    logic        clk;
    logic        rst;
    logic        en_ram_in;
    logic        en_pc_pulse;
    logic [1:0]  pc_ctrl;
    logic [7:0]  offset_addr;
    logic [15:0] ins;
    logic        en_ram_out;
    logic [7:0]  pc;
    logic        busy;
    logic        fetch_err;

    ins_fetch_if #(.DWIDTH(16), .AWIDTH(8)) mif ();

    ins_fetch #(
        .DWIDTH(16),
        .AWIDTH(8),
        .TIMEOUT(15)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en_ram_in  (en_ram_in),
        .en_pc_pulse(en_pc_pulse),
        .pc_ctrl    (pc_ctrl),
        .offset_addr(offset_addr),
        .mem        (mif.master),
        .ins        (ins),
        .en_ram_out (en_ram_out),
        .pc         (pc),
        .busy       (busy),
        .fetch_err  (fetch_err)
    );

    logic [15:0] memory [256];
    assign mif.mem_rdata = memory[mif.mem_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int addr;
        int data;
    } fetch_t;

    typedef struct {
        int due;
        int pc;
        int err;
        int busy;
        int rd;
        int out;
        int ins;
    } exp_t;

    fetch_t fq[$];
    exp_t   eq[$];

    int vectors = 0;
    int fails   = 0;
    int m_pc    = 0;
    int m_err   = 0;
    int m_ins   = 0;

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int next_pc(input int p, input logic [1:0] ctrl, input logic [7:0] off);
        int soff;
        soff = (off >= 8'd128) ? int'(off) - 256 : int'(off);
        case (ctrl)
            2'b00:   return (p + 1) % 256;
            2'b01:   return int'(off);
            2'b10:   return ((p + soff) % 256 + 256) % 256;
            default: return p;
        endcase
    endfunction

    function automatic bit rb(input int n);
        return ($urandom % n) == 0;
    endfunction

    always @(negedge clk) begin
        exp_t   e;
        fetch_t f;
        while (eq.size() > 0 && eq[0].due <= cyc) begin
            e = eq.pop_front();
            chk("pc", int'(pc), e.pc);
            chk("busy", int'(busy), e.busy);
            chk("mem_rd", int'(mif.mem_rd), e.rd);
            chk("en_ram_out", int'(en_ram_out), e.out);
            chk("fetch_err", int'(fetch_err), e.err);
            chk("ins_held", int'(ins), e.ins);
        end
        if (mif.mem_rd && fq.size() > 0) begin
            chk("mem_addr", int'(mif.mem_addr), fq[0].addr);
        end
        if (en_ram_out) begin
            if (fq.size() == 0) begin
                vectors++;
                fails++;
                $display("FAIL unexpected_en_ram_out: got pulse expected none (cycle %0d)", cyc);
            end else begin
                f = fq.pop_front();
                chk("fetched_ins", int'(ins), f.data);
            end
        end
    end

    // One clock of stimulus; cur_busy/nb/nrd/nout describe the fetch phase now and after this edge.
    task automatic step(input bit r, input bit req, input bit pe, input logic [1:0] ctrl,
                        input logic [7:0] off, input bit ack, input bit cur_busy,
                        input bit nb, input bit nrd, input bit nout);
        exp_t e;
        @(posedge clk);
        #1;
        rst         = r;
        en_ram_in   = req;
        en_pc_pulse = pe;
        pc_ctrl     = ctrl;
        offset_addr = off;
        mif.mem_ack = ack;
        if (r) begin
            m_pc  = 0;
            m_err = 0;
            m_ins = 0;
            fq.delete();
        end else begin
            if (req && !cur_busy) fq.push_back('{addr: m_pc, data: int'(memory[m_pc])});
            else if (req) m_err = 1;
            if (pe) m_pc = next_pc(m_pc, ctrl, off);
            if (nout && fq.size() > 0) m_ins = fq[0].data;
        end
        e.due  = cyc + 1;
        e.pc   = m_pc;
        e.err  = m_err;
        e.busy = r ? 0 : int'(nb);
        e.rd   = r ? 0 : int'(nrd);
        e.out  = r ? 0 : int'(nout);
        e.ins  = m_ins;
        eq.push_back(e);
    endtask

    task automatic do_fetch(input int delay, input bit force_extra, input bit noise);
        int gap;
        gap = noise ? int'($urandom_range(0, 2)) : 0;
        for (int i = 0; i < gap; i++)
            step(0, 0, noise && rb(3), 2'($urandom), 8'($urandom), noise && rb(4), 0, 0, 0, 0);
        step(0, 1, noise && rb(3), 2'($urandom), 8'($urandom), 0, 0, 1, 1, 0);
        for (int i = 0; i < delay; i++) begin
            if (noise && i == 0 && rb(15)) begin
                step(1, 0, 0, 2'b00, 8'h00, 0, 1, 0, 0, 0);
                return;
            end
            step(0, (force_extra && i == 0) || (noise && rb(8)), noise && rb(3),
                 2'($urandom), 8'($urandom), 0, 1, 1, 1, 0);
        end
        step(0, noise && rb(8), noise && rb(3), 2'($urandom), 8'($urandom), 1, 1, 1, 0, 1);
        step(0, noise && rb(8), noise && rb(3), 2'($urandom), 8'($urandom), noise && rb(4), 1, 0, 0, 0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) memory[i] = 16'($urandom);
        memory[0] = 16'h1234;
        rst = 1'b1; en_ram_in = 1'b0; en_pc_pulse = 1'b0;
        pc_ctrl = 2'b00; offset_addr = 8'h00; mif.mem_ack = 1'b0;

        step(1, 0, 0, 2'b00, 8'h00, 0, 0, 0, 0, 0);
        step(1, 0, 0, 2'b00, 8'h00, 0, 0, 0, 0, 0);

        // minimum-latency fetch of address 0
        do_fetch(0, 0, 0);

        // PC wrap, jump, negative branch, hold
        step(0, 0, 1, PC_CTRL_JMP,  8'hFF, 0, 0, 0, 0, 0);
        step(0, 0, 1, PC_CTRL_INC,  8'h00, 0, 0, 0, 0, 0);
        step(0, 0, 1, PC_CTRL_JMP,  8'h40, 0, 0, 0, 0, 0);
        step(0, 0, 1, PC_CTRL_REL,  8'hFE, 0, 0, 0, 0, 0);
        step(0, 0, 1, PC_CTRL_HOLD, 8'h77, 0, 0, 0, 0, 0);

        // fetch uses the pre-update pc when a jump lands in the same cycle
        step(0, 0, 1, PC_CTRL_JMP, 8'h05, 0, 0, 0, 0, 0);
        step(0, 1, 1, PC_CTRL_JMP, 8'h20, 0, 0, 1, 1, 0);
        step(0, 0, 0, 2'b00, 8'h00, 1, 1, 1, 0, 1);
        step(0, 0, 0, 2'b00, 8'h00, 0, 1, 0, 0, 0);

        // stalled ack with a dropped second request
        do_fetch(3, 1, 0);

        // reset during REQ, late ack afterwards
        step(0, 1, 0, 2'b00, 8'h00, 0, 0, 1, 1, 0);
        step(1, 0, 0, 2'b00, 8'h00, 0, 1, 0, 0, 0);
        step(0, 0, 0, 2'b00, 8'h00, 1, 0, 0, 0, 0);
        step(0, 0, 0, 2'b00, 8'h00, 0, 0, 0, 0, 0);

`ifdef IF_TIMEOUT_EN
        step(0, 1, 0, 2'b00, 8'h00, 0, 0, 1, 1, 0);
        for (int i = 0; i < 14; i++) step(0, 0, 0, 2'b00, 8'h00, 0, 1, 1, 1, 0);
        m_err = 1;
        fq[0].data = int'(NOP_WORD_DEFAULT);
        step(0, 0, 0, 2'b00, 8'h00, 0, 1, 1, 0, 1);
        step(0, 0, 0, 2'b00, 8'h00, 0, 1, 0, 0, 0);
`endif

        for (int n = 0; n < 300; n++) do_fetch(int'($urandom_range(0, 8)), 0, 1);

        for (int i = 0; i < 3; i++) step(0, 0, 0, 2'b00, 8'h00, 0, 0, 0, 0, 0);
        @(negedge clk);
        #1;
        chk("fetch_queue_drained", fq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
